// File: rtl/power_level_ramp.sv
// rtl/power_level_ramp.sv - power level ramp controller with optional PWM drive (macro PWR_PWM_EN)
module power_level_ramp #(
   parameter int STEP_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [3:0] chs_power,
   input  logic       chs_mode,
   output logic [3:0] pwr_level,
   output logic       busy,
   output logic       done,
   output logic       pwm_out
);

   // A one-cycle step period still needs a 1-bit prescaler that always reads as wrapped.
   localparam int             PW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PW-1:0]  PRE_MAX = PW'(STEP_DIV - 1);
   localparam logic [PW-1:0]  PRE_ONE = PW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RAMP = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    pwr_level_q, pwr_level_d;
   logic [3:0]    target_q, target_d;
   logic [PW-1:0] prescaler_q, prescaler_d;
   logic [3:0]    next_step;
   logic          at_wrap;

   // Next-state logic: accept a request in IDLE, step the level once per prescaler wrap.
   always_comb begin
      state_d     = state_q;
      pwr_level_d = pwr_level_q;
      target_d    = target_q;
      prescaler_d = prescaler_q;
      at_wrap     = (prescaler_q == PRE_MAX);

      // Saturating move toward the target: never wraps past 0 or 15.
      if (pwr_level_q < target_q) begin
         next_step = pwr_level_q + 4'd1;
      end else if (pwr_level_q > target_q) begin
         next_step = pwr_level_q - 4'd1;
      end else begin
         next_step = pwr_level_q;
      end

      case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               target_d = chs_power;
               if (chs_mode) begin
                  pwr_level_d = chs_power;
                  state_d     = S_DONE;
               end else if (chs_power == pwr_level_q) begin
                  state_d     = S_DONE;
               end else begin
                  prescaler_d = '0;
                  state_d     = S_RAMP;
               end
            end
         end
         S_RAMP: begin
            if (at_wrap) begin
               prescaler_d = '0;
               pwr_level_d = next_step;
               if (next_step == target_q) begin
                  state_d = S_DONE;
               end
            end else begin
               prescaler_d = prescaler_q + PRE_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, level, target and prescaler registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pwr_level_q <= 4'd0;
         target_q    <= 4'd0;
         prescaler_q <= '0;
      end else begin
         state_q     <= state_d;
         pwr_level_q <= pwr_level_d;
         target_q    <= target_d;
         prescaler_q <= prescaler_d;
      end
   end

   assign cfg_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign pwr_level = pwr_level_q;

`ifdef PWR_PWM_EN
   logic [3:0] pwm_cnt_q, pwm_cnt_d;
   logic       pwm_q, pwm_d;

   // Period-15 counter; comparing against 0..15 gives full off and full on at the extremes.
   always_comb begin
      pwm_cnt_d = (pwm_cnt_q == 4'd14) ? 4'd0 : pwm_cnt_q + 4'd1;
      pwm_d     = (pwm_cnt_q < pwr_level_q);
   end

   // PWM counter and registered drive.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_cnt_q <= 4'd0;
         pwm_q     <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         pwm_q     <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;
`else
   assign pwm_out = 1'b0;
`endif

endmodule
